// File: rtl/event_stretch.sv
// Stretches single-cycle event strobes into fixed-length LED blinks separated by a
// guaranteed off gap; events arriving during a blink are queued and replayed.
module event_stretch #(
   parameter int unsigned ON_COUNT  = 5_000_000,
   parameter int unsigned OFF_COUNT = 2_500_000,
   parameter int unsigned PEND_W    = 4
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_event,
   input  logic              i_clr,
   output logic              o_led,
   output logic              o_busy,
   output logic [PEND_W-1:0] o_pending,
   output logic              o_overflow
);

   localparam int unsigned CNT_W = 32;
   localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_COUNT - 1);
   localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_COUNT - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ON   = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             led_q, led_d;
   logic             busy_q, busy_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic             ovf_q, ovf_d;
   logic             on_last, gap_last;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      led_d    = led_q;
      busy_d   = busy_q;
      pend_d   = pend_q;
      ovf_d    = ovf_q;
      on_last  = (state_q == S_ON)  && (cnt_q == ON_LAST);
      gap_last = (state_q == S_GAP) && (cnt_q == OFF_LAST);

      // Queue events seen while busy; the last gap cycle is resolved below
      if (i_clr) begin
         pend_d = '0;
         ovf_d  = 1'b0;
      end else if (i_event && (state_q != S_IDLE) && !gap_last) begin
         if (pend_q == PEND_MAX) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (i_event) begin
               state_d = S_ON;
               cnt_d   = '0;
               led_d   = 1'b1;
               busy_d  = 1'b1;
            end
         end
         S_ON: begin
            if (on_last) begin
               state_d = S_GAP;
               cnt_d   = '0;
               led_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (gap_last) begin
               cnt_d = '0;
               // A concurrent event and a queued replay cancel, leaving pending unchanged
               if (!i_clr && ((pend_q != '0) || i_event)) begin
                  state_d = S_ON;
                  led_d   = 1'b1;
                  if ((pend_q != '0) && !i_event) begin
                     pend_d = pend_q - 1'b1;
                  end
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            led_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         led_q   <= 1'b0;
         busy_q  <= 1'b0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end

   assign o_led      = led_q;
   assign o_busy     = busy_q;
   assign o_pending  = pend_q;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_event_stretch.sv
// Scoreboard bench for event_stretch (ON=4, OFF=3, PEND_W=2): stimulus pushes the
// hand-computed outputs expected after each clock edge, a monitor pops and compares.
module tb_event_stretch;

   typedef struct packed {
      logic       led;
      logic       busy;
      logic [1:0] pend;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ev = 1'b0;
   logic       clr = 1'b0;
   logic       led, busy, ovf;
   logic [1:0] pend;

   exp_t  exp_q[$];
   string tag_q[$];
   string tag = "init";
   exp_t  mon_x;
   string mon_t;
   int    total = 0;
   int    bad = 0;

   event_stretch #(.ON_COUNT(4), .OFF_COUNT(3), .PEND_W(2)) dut (
      .i_clk(clk), .i_rstn(rst_n), .i_event(ev), .i_clr(clr),
      .o_led(led), .o_busy(busy), .o_pending(pend), .o_overflow(ovf)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs and queue the outputs expected after the next edge
   task automatic step(input logic e, input logic c, input logic l, input logic b,
                       input logic [1:0] p, input logic o);
      exp_t x;
      @(negedge clk);
      ev = e;
      clr = c;
      x.led = l; x.busy = b; x.pend = p; x.ovf = o;
      exp_q.push_back(x);
      tag_q.push_back(tag);
   endtask

   task automatic rep(input int n, input logic l, input logic b,
                      input logic [1:0] p, input logic o);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, l, b, p, o);
   endtask

   task automatic check_now(input string name, input exp_t want);
      total++;
      if ({led, busy, pend, ovf} !== want) begin
         bad++;
         $display("FAIL %s: got led=%b busy=%b pend=%0d ovf=%b, want led=%b busy=%b pend=%0d ovf=%b",
                  name, led, busy, pend, ovf, want.led, want.busy, want.pend, want.ovf);
      end
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 20) begin
         @(posedge clk);
         #2;
         k++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d queued entries, want 0", exp_q.size());
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_x = exp_q.pop_front();
         mon_t = tag_q.pop_front();
         total++;
         if ({led, busy, pend, ovf} !== mon_x) begin
            bad++;
            $display("FAIL %s @%0t: got led=%b busy=%b pend=%0d ovf=%b, want led=%b busy=%b pend=%0d ovf=%b",
                     mon_t, $time, led, busy, pend, ovf, mon_x.led, mon_x.busy, mon_x.pend, mon_x.ovf);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check_now("reset_state", 5'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Async reset mid-ON with a pending event, then a normal blink
      tag = "rst_mid";
      step(1, 0, 1, 1, 0, 0);
      step(1, 0, 1, 1, 1, 0);
      drain();
      ev = 1'b0;
      rst_n = 1'b0;
      #1;
      check_now("rst_async", 5'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tag = "rst_after";
      step(1, 0, 1, 1, 0, 0);
      rep(3, 1, 1, 0, 0);
      rep(3, 0, 1, 0, 0);
      rep(2, 0, 0, 0, 0);

      // Single event
      tag = "single";
      step(1, 0, 1, 1, 0, 0);
      rep(3, 1, 1, 0, 0);
      rep(3, 0, 1, 0, 0);
      rep(2, 0, 0, 0, 0);

      // Events at 10,12,13,14: four back-to-back blinks
      tag = "queue4";
      step(1, 0, 1, 1, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      step(1, 0, 1, 1, 1, 0);
      step(1, 0, 1, 1, 2, 0);
      step(1, 0, 0, 1, 3, 0);
      rep(2, 0, 1, 3, 0);
      rep(4, 1, 1, 2, 0);
      rep(3, 0, 1, 2, 0);
      rep(4, 1, 1, 1, 0);
      rep(3, 0, 1, 1, 0);
      rep(4, 1, 1, 0, 0);
      rep(3, 0, 1, 0, 0);
      rep(2, 0, 0, 0, 0);

      // Saturation and overflow, then clear during the gap
      tag = "overflow";
      step(1, 0, 1, 1, 0, 0);
      step(1, 0, 1, 1, 1, 0);
      step(1, 0, 1, 1, 2, 0);
      step(1, 0, 1, 1, 3, 0);
      step(1, 0, 0, 1, 3, 1);
      tag = "clr_gap";
      step(0, 1, 0, 1, 0, 0);
      rep(1, 0, 1, 0, 0);
      rep(2, 0, 0, 0, 0);

      // Pending 0, event on last gap cycle
      tag = "gap_last_p0";
      step(1, 0, 1, 1, 0, 0);
      rep(3, 1, 1, 0, 0);
      rep(3, 0, 1, 0, 0);
      step(1, 0, 1, 1, 0, 0);
      rep(3, 1, 1, 0, 0);
      rep(3, 0, 1, 0, 0);
      rep(2, 0, 0, 0, 0);

      // Pending 2, event on last gap cycle cancels the decrement
      tag = "gap_last_p2";
      step(1, 0, 1, 1, 0, 0);
      step(1, 0, 1, 1, 1, 0);
      step(1, 0, 1, 1, 2, 0);
      step(0, 0, 1, 1, 2, 0);
      rep(3, 0, 1, 2, 0);
      step(1, 0, 1, 1, 2, 0);
      rep(3, 1, 1, 2, 0);
      rep(3, 0, 1, 2, 0);
      rep(4, 1, 1, 1, 0);
      rep(3, 0, 1, 1, 0);
      rep(4, 1, 1, 0, 0);
      rep(3, 0, 1, 0, 0);
      rep(2, 0, 0, 0, 0);

      // Clear with event: idle starts a blink, during ON the event is discarded
      tag = "clr_ev";
      step(1, 1, 1, 1, 0, 0);
      step(1, 0, 1, 1, 1, 0);
      step(1, 1, 1, 1, 0, 0);
      rep(1, 1, 1, 0, 0);
      rep(3, 0, 1, 0, 0);
      rep(2, 0, 0, 0, 0);

      // Clear with event on last gap cycle returns to idle
      tag = "clr_ev_gap_last";
      step(1, 0, 1, 1, 0, 0);
      rep(3, 1, 1, 0, 0);
      rep(3, 0, 1, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      rep(2, 0, 0, 0, 0);

      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
